// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - 5-stage pipeline stall/clear sequencing, EX forwarding and dmem wait FSM
// Debug counters track stall cycles and branch flush cycles.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_pc_src,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_req,
  input  logic             dmem_ack,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             if_stall,
  output logic             de_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             de_clear,
  output logic             ex_clear,
  output logic             wb_clear,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_MEM_ERR
  } state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic [CNT_W-1:0]   flush_count_q, flush_count_d;

  logic mem_freeze;
  logic load_use;

  // MEM result is younger than WB, so it takes priority.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      return 2'b10;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    load_use   = ex_is_load && (ex_rd != 5'd0) && ((ex_rd == de_rs1) || (ex_rd == de_rs2));
    mem_freeze = ((state_q == ST_RUN) && mem_req && !dmem_ack) ||
                 (state_q == ST_MEM_WAIT) || (state_q == ST_MEM_ERR);
  end

  always_comb begin
    if_stall  = 1'b0;
    de_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    de_clear  = 1'b0;
    ex_clear  = 1'b0;
    wb_clear  = 1'b0;
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (rst_n) begin
      forward_a = fwd_sel(ex_rs1);
      forward_b = fwd_sel(ex_rs2);
      // Freeze defers branch and load-use; WB gets a bubble so nothing writes twice.
      if (mem_freeze) begin
        if_stall  = 1'b1;
        de_stall  = 1'b1;
        ex_stall  = 1'b1;
        mem_stall = 1'b1;
        wb_clear  = 1'b1;
      end else if (ex_pc_src) begin
        de_clear = 1'b1;
        ex_clear = 1'b1;
      end else if (load_use) begin
        if_stall = 1'b1;
        de_stall = 1'b1;
        ex_clear = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_req && !dmem_ack) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_MEM_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_MEM_ERR: begin
        state_d = ST_MEM_ERR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, if_stall};
    flush_count_d = flush_count_q + {{(CNT_W-1){1'b0}}, de_clear};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign mem_timeout_err = (state_q == ST_MEM_ERR);
  assign stall_count     = stall_count_q;
  assign flush_count     = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed checks of hazard controller outputs, FSM and counters
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        rst_n;
  logic [4:0]  de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        ex_is_load, ex_pc_src, mem_reg_write, mem_req, dmem_ack, wb_reg_write;
  logic        if_stall, de_stall, ex_stall, mem_stall, de_clear, ex_clear, wb_clear;
  logic [1:0]  forward_a, forward_b;
  logic        mem_timeout_err;
  logic [31:0] stall_count, flush_count;
  logic [6:0]  ctl;

  int checks;
  int errors;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_FRZ  = 7'b1111001;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_LU   = 7'b1100010;

  pipeline_hazard_controller #(
    .MEM_TIMEOUT(4),
    .CNT_W      (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .de_rs1         (de_rs1),
    .de_rs2         (de_rs2),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_is_load     (ex_is_load),
    .ex_pc_src      (ex_pc_src),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_req        (mem_req),
    .dmem_ack       (dmem_ack),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .if_stall       (if_stall),
    .de_stall       (de_stall),
    .ex_stall       (ex_stall),
    .mem_stall      (mem_stall),
    .de_clear       (de_clear),
    .ex_clear       (ex_clear),
    .wb_clear       (wb_clear),
    .forward_a      (forward_a),
    .forward_b      (forward_b),
    .mem_timeout_err(mem_timeout_err),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  assign ctl = {if_stall, de_stall, ex_stall, mem_stall, de_clear, ex_clear, wb_clear};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    de_rs1 = 0; de_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_is_load = 0; ex_pc_src = 0; mem_reg_write = 0; mem_req = 0; dmem_ack = 0; wb_reg_write = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr_inputs();
    rst_n = 1'b0;

    // Reset: outputs forced low even with active inputs
    mem_req = 1; ex_pc_src = 1; ex_is_load = 1; ex_rd = 3; de_rs1 = 3;
    ex_rs1 = 9; mem_rd = 9; mem_reg_write = 1;
    tick(); tick();
    check("rst_ctl", 32'(ctl), 32'(C_NONE));
    check("rst_fwd_a", 32'(forward_a), 32'd0);
    check("rst_stall_cnt", stall_count, 32'd0);
    check("rst_flush_cnt", flush_count, 32'd0);
    check("rst_err", 32'(mem_timeout_err), 32'd0);
    clr_inputs();
    rst_n = 1'b1;
    #1;
    check("idle_ctl", 32'(ctl), 32'(C_NONE));

    // Forwarding
    ex_rs1 = 7; ex_rs2 = 7; mem_rd = 7; mem_reg_write = 1; wb_rd = 7; wb_reg_write = 1;
    #1;
    check("fwd_a_mem", 32'(forward_a), 32'd2);
    check("fwd_b_mem", 32'(forward_b), 32'd2);
    mem_reg_write = 0;
    #1;
    check("fwd_a_wb", 32'(forward_a), 32'd1);
    ex_rs1 = 0;
    #1;
    check("fwd_a_x0", 32'(forward_a), 32'd0);
    check("fwd_b_wb", 32'(forward_b), 32'd1);
    mem_reg_write = 1; mem_rd = 0; wb_reg_write = 0;
    #1;
    check("fwd_b_memrd0", 32'(forward_b), 32'd0);
    clr_inputs();

    // Load-use: one bubble
    ex_is_load = 1; ex_rd = 5; de_rs2 = 5;
    #1;
    check("lu_ctl", 32'(ctl), 32'(C_LU));
    tick();
    clr_inputs();
    #1;
    check("lu_after_ctl", 32'(ctl), 32'(C_NONE));
    check("lu_stall_cnt", stall_count, 32'd1);
    ex_is_load = 1; ex_rd = 0; de_rs1 = 0; de_rs2 = 0;
    #1;
    check("lu_x0_ctl", 32'(ctl), 32'(C_NONE));
    ex_rd = 6; de_rs1 = 6;
    #1;
    check("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
    clr_inputs();

    // Branch, then branch over load-use
    ex_pc_src = 1;
    #1;
    check("br_ctl", 32'(ctl), 32'(C_BR));
    tick();
    ex_pc_src = 0;
    #1;
    check("br_flush_cnt", flush_count, 32'd1);
    check("br_after_ctl", 32'(ctl), 32'(C_NONE));
    ex_pc_src = 1; ex_is_load = 1; ex_rd = 5; de_rs2 = 5;
    #1;
    check("br_lu_ctl", 32'(ctl), 32'(C_BR));
    tick();
    clr_inputs();
    #1;
    check("br_lu_flush_cnt", flush_count, 32'd2);
    check("br_lu_stall_cnt", stall_count, 32'd1);

    // Memory wait: ack low 3 cycles, then high
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      ex_pc_src = (i == 1);
      #1;
      check($sformatf("mw_ctl_%0d", i), 32'(ctl), 32'(C_FRZ));
      tick();
    end
    clr_inputs();
    #1;
    check("mw_run_ctl", 32'(ctl), 32'(C_NONE));
    check("mw_stall_cnt", stall_count, 32'd5);
    check("mw_flush_cnt", flush_count, 32'd2);
    mem_req = 1; dmem_ack = 1;
    #1;
    check("zw_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    clr_inputs();
    #1;
    check("zw_next_ctl", 32'(ctl), 32'(C_NONE));
    check("zw_stall_cnt", stall_count, 32'd5);

    // Reset asserted mid-wait
    mem_req = 1;
    tick();
    mem_req = 0;
    #1;
    check("rw_wait_ctl", 32'(ctl), 32'(C_FRZ));
    #1;
    rst_n = 1'b0;
    #1;
    check("rw_async_ctl", 32'(ctl), 32'(C_NONE));
    check("rw_async_stall_cnt", stall_count, 32'd0);
    check("rw_async_flush_cnt", flush_count, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rw_run_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    check("rw_run_ctl2", 32'(ctl), 32'(C_NONE));
    check("rw_stall_cnt", stall_count, 32'd0);

    // Timeout with MEM_TIMEOUT=4
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("to_ctl_%0d", i), 32'(ctl), 32'(C_FRZ));
      check($sformatf("to_err_%0d", i), 32'(mem_timeout_err), 32'd0);
      tick();
    end
    check("to_err_set", 32'(mem_timeout_err), 32'd1);
    check("to_stall_cnt", stall_count, 32'd4);
    mem_req = 0; dmem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("to_err_hold_%0d", i), 32'(mem_timeout_err), 32'd1);
      check($sformatf("to_hold_ctl_%0d", i), 32'(ctl), 32'(C_FRZ));
    end
    check("to_stall_cnt_end", stall_count, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central sequencer for the 5-stage core pipeline. It generates the stall and clear controls for every pipeline register: if_stall, de_stall, de_clear, ex_clear, ex_stall, mem_stall and wb_clear. It also produces EX-stage operand forwarding selects and runs a small FSM that freezes the pipeline while the data memory has not acknowledged an access. Performance counters for stall and flush cycles are kept for debug.

Parameters:
MEM_TIMEOUT, 64, max cycles in MEM_WAIT before entering the sticky MEM_ERR state.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
de_rs1  in  5  source reg 1 of instruction in DE
de_rs2  in  5  source reg 2 of instruction in DE
ex_rs1  in  5  source reg 1 of instruction in EX
ex_rs2  in  5  source reg 2 of instruction in EX
ex_rd  in  5  dest reg of instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_pc_src  in  1  EX resolved taken branch/jump (same signal fed to fetch)
mem_rd  in  5  dest reg in MEM
mem_reg_write  in  1  MEM instruction writes register file
mem_req  in  1  MEM instruction accesses data memory
dmem_ack  in  1  data memory completes access this cycle
wb_rd  in  5  dest reg in WB
wb_reg_write  in  1  WB instruction writes register file
if_stall, de_stall, ex_stall, mem_stall  out  1 each  hold respective pipeline register / PC
de_clear, ex_clear, wb_clear  out  1 each  synchronous clear of respective pipeline register
forward_a, forward_b  out  2 each  EX operand select: 00 regfile, 01 WB result, 10 MEM result
mem_timeout_err  out  1  sticky, set in MEM_ERR
stall_count  out  CNT_W  cycles with if_stall=1
flush_count  out  CNT_W  cycles with de_clear=1 due to branch

Behaviour:
- Reset (rst_n=0, async): FSM=RUN, wait counter=0, stall_count=0, flush_count=0, mem_timeout_err=0.
- In reset, all stall/clear outputs=0 and forward_a/b=00. While reset is asserted, control outputs are forced low regardless of inputs.
- Forwarding is combinational, evaluated per operand (shown for rs1/forward_a; forward_b identical with ex_rs2):
  - 10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1;
  - else 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1;
  - else 00. MEM has priority over WB.
- load_use = ex_is_load && ex_rd!=0 && (ex_rd==de_rs1 || ex_rd==de_rs2).
- mem_freeze = (state==RUN && mem_req && !dmem_ack) || state==MEM_WAIT || state==MEM_ERR.
- Control outputs are combinational, evaluated in this priority order:
  1. mem_freeze: if_stall=de_stall=ex_stall=mem_stall=1, wb_clear=1 (bubble into WB, no double write). All other clears=0. A branch or load_use is deferred until the freeze ends.
  2. ex_pc_src: de_clear=1, ex_clear=1, no stalls. Branch wins over load_use, because a wrong-path DE instruction is discarded anyway.
  3. load_use: if_stall=1, de_stall=1, ex_clear=1 (one bubble). Lasts exactly one cycle because the load advances to MEM next cycle.
  4. Otherwise all 0.
- FSM (registered):
  - RUN: on mem_req && !dmem_ack, go to MEM_WAIT with wait counter=1. On mem_req && dmem_ack, stay (zero-wait access, no stall).
  - MEM_WAIT: if dmem_ack, go to RUN and clear the counter; stalls are still asserted in the ack cycle and the pipeline advances on the next edge. Else, if counter==MEM_TIMEOUT-1, go to MEM_ERR. Else counter+1.
  - MEM_ERR: sticky until reset, mem_timeout_err=1, pipeline frozen. dmem_ack is ignored.
- Counters: stall_count increments on every cycle with if_stall=1; flush_count increments on every cycle with de_clear=1. Both wrap modulo 2^CNT_W with no saturation.
- Reset asserted mid-MEM_WAIT returns to RUN immediately; the pending access is abandoned.

Test Plan:
- Load-use: EX lw x5 (ex_is_load=1, ex_rd=5), DE de_rs2=5 -> exactly 1 cycle if_stall=de_stall=ex_clear=1; stall_count=1. With ex_rd=0 -> no stall.
- Branch: ex_pc_src=1 for 1 cycle -> de_clear=ex_clear=1 that cycle, no stalls, flush_count=1. ex_pc_src=1 together with load_use -> only clears, no stall.
- Forwarding: ex_rs1=7, mem_rd=7/mem_reg_write=1, wb_rd=7/wb_reg_write=1 -> forward_a=10. Drop mem_reg_write -> 01. Set ex_rs1=0 -> 00.
- Memory wait: mem_req=1, dmem_ack low 3 cycles then high -> freeze asserted 4 cycles (including ack cycle), wb_clear=1 during them, FSM back to RUN, stall_count=4.
- Timeout: MEM_TIMEOUT=4, mem_req=1, dmem_ack never -> MEM_ERR entered after 4 frozen cycles, mem_timeout_err=1 and held; a later dmem_ack has no effect.
- Reset mid-wait: rst_n low during MEM_WAIT -> outputs 0 asynchronously; counters=0, FSM=RUN after release.
